// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy encoding and default widths for pipe_stage_buf
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one ctrl+data holding register; clear squashes ctrl only
module pipe_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Data is deliberately left untouched on clear: only ctrl carries side effects.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage register with valid/ready, 2-entry skid, flush and stall counter
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stat_clr
);

  occ_e              r_state;
  occ_e              w_state_nxt;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_out_valid;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_out_valid = (r_state != OCC_EMPTY);
  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = w_out_valid & out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != OCC_FULL);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (Flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = OCC_ONE;
            w_main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = OCC_FULL;
            w_skid_load = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt      = OCC_ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_main_load),
    .i_clr  (Flush),
    .i_ctrl (w_main_ctrl_in),
    .i_data (w_main_data_in),
    .o_ctrl (w_main_ctrl),
    .o_data (w_main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_skid_load),
    .i_clr  (Flush),
    .i_ctrl (in_ctrl),
    .i_data (in_data),
    .o_ctrl (w_skid_ctrl),
    .o_data (w_skid_data)
  );

  // Saturating stall counter; a clear beats a same-cycle increment.
  always_ff @(posedge Clk) begin
    if (Reset || stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? w_main_ctrl : '0;
  assign out_data  = w_main_data;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

  a_occ_legal: assert property (@(posedge Clk) disable iff (Reset)
    r_state inside {OCC_EMPTY, OCC_ONE, OCC_FULL});

  a_no_accept_when_full: assert property (@(posedge Clk) disable iff (Reset)
    (r_state == OCC_FULL) |-> !r_in_ready);

endmodule
